uart_rx: RTL and testbench

- 8N1 UART receiver; the downstream consumer of the uart_tx serial line.
- Oversamples the asynchronous rx line with the system clock, recovers each byte LSB first, and presents it with a one-cycle valid strobe.
- Flags frames whose stop bit is low.
- Used in loopback tests against uart_tx and as the host-to-FPGA serial input.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_if.sv | 14 +
 rtl/uart_rx_sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit period and receiver states.
// Pure declarations; no latency, no flow control.
package uart_pkg;
  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;
endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side serial line plus recovered byte, strobes and busy flag.
// Wiring only; strobes carry no backpressure, the consumer takes data on valid.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  modport master (output rx, input data, input valid, input frame_err, input busy);
  modport slave  (input rx, output data, output valid, output frame_err, output busy);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, reset to a chosen idle level.
// Latency: q follows d after two clk edges; no backpressure.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synced rx, mid-bit sampling, byte out with a one-cycle valid.
// Latency: valid 2+C/2+9C+2 clocks after the start edge; no backpressure, consumer must take data on valid.
module uart_rx #(
  parameter int CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);
  import uart_pkg::*;

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic                 rx_s;
  logic                 rx_d;
  logic [1:0]           warm;
  rx_state_t            state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [2:0]           bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 done_ok, done_ok_nxt;
  logic                 done_err, done_err_nxt;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  // rx_d is held low until the synchronizer has flushed its reset value, so a
  // line that is already low at reset release cannot look like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      warm <= 2'b00;
      rx_d <= 1'b0;
    end else begin
      warm <= {warm[0], 1'b1};
      rx_d <= warm[1] ? rx_s : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      done_ok  <= 1'b0;
      done_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      done_ok  <= done_ok_nxt;
      done_err <= done_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    done_ok_nxt  = 1'b0;
    done_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s && rx_d) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = DATA;
            cnt_nxt     = '0;
            bit_idx_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          shift_nxt   = {rx_s, shift[DATA_BITS-1:1]};
          cnt_nxt     = '0;
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        // Decision lands mid stop bit, so IDLE is back in time for a
        // start edge that follows the stop bit directly.
        if (cnt == BIT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            done_ok_nxt = 1'b1;
            state_nxt   = IDLE;
          end else begin
            done_err_nxt = 1'b1;
            state_nxt    = BREAK;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= done_ok;
      ferr_q  <= done_err;
      if (done_ok) data_q <= shift;
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at four clocks per bit, with a behavioural serial driver.
module tb_uart_rx;
  localparam int C   = 4;
  localparam int LAT = 2 + C / 2 + 9 * C + 2;

  logic clk;
  logic rst;
  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks;
  int          errors;
  logic [7:0]  got_q[$];
  int          ferr_cnt;
  int          both_cnt;
  int          wide_cnt;
  time         last_valid_t;
  logic        prev_v;
  logic        prev_f;
  logic [7:0]  last_good;

  initial begin
    prev_v = 1'b0;
    prev_f = 1'b0;
    ferr_cnt = 0;
    both_cnt = 0;
    wide_cnt = 0;
    last_valid_t = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.valid === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
      if (bus.valid === 1'b1) begin
        got_q.push_back(bus.data);
        last_valid_t = $time;
      end
      if (bus.frame_err === 1'b1) ferr_cnt++;
      if ((bus.valid === 1'b1 && prev_v) || (bus.frame_err === 1'b1 && prev_f)) wide_cnt++;
      prev_v = (bus.valid === 1'b1);
      prev_f = (bus.frame_err === 1'b1);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    bus.rx = 1'b0;
    cycles(C);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      cycles(C);
    end
    bus.rx = stop_v;
    cycles(C);
    bus.rx = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.rx = 1'b1;
    cycles(3);
    checks++;
    if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    checks++;
    if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", bus.frame_err); end
    checks++;
    if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.data); end
    rst = 1'b0;
    cycles(6);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    last_good = 8'h00;
  endtask

  task automatic test_single_byte;
    int  base;
    int  fe0;
    time t0;
    base = got_q.size();
    fe0  = ferr_cnt;
    t0   = $time;
    send_frame(8'h48, 1'b1);
    cycles(4);
    checks++;
    if (got_q.size() != base + 1) begin
      errors++; $display("FAIL single_count got %0d want %0d", got_q.size() - base, 1);
    end else begin
      checks++;
      if (got_q[base] !== 8'h48) begin errors++; $display("FAIL single_data got %h want 48", got_q[base]); end
      checks++;
      if (last_valid_t - t0 != 10 * LAT) begin
        errors++; $display("FAIL single_latency got %0d want %0d", (last_valid_t - t0) / 10, LAT);
      end
      last_good = 8'h48;
    end
    checks++;
    if (ferr_cnt != fe0) begin errors++; $display("FAIL single_ferr got %0d want 0", ferr_cnt - fe0); end
    checks++;
    if (bus.data !== 8'h48) begin errors++; $display("FAIL single_hold got %h want 48", bus.data); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp[3];
    int base;
    int fe0;
    exp[0] = 8'h55; exp[1] = 8'h00; exp[2] = 8'hFF;
    base = got_q.size();
    fe0  = ferr_cnt;
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
    cycles(6);
    checks++;
    if (got_q.size() != base + 3) begin
      errors++; $display("FAIL b2b_count got %0d want 3", got_q.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[base+i] !== exp[i]) begin errors++; $display("FAIL b2b_data%0d got %h want %h", i, got_q[base+i], exp[i]); end
      end
    end
    last_good = 8'hFF;
    checks++;
    if (ferr_cnt != fe0) begin errors++; $display("FAIL b2b_ferr got %0d want 0", ferr_cnt - fe0); end
  endtask

  task automatic test_glitch;
    int base;
    int fe0;
    int hcnt;
    base = got_q.size();
    fe0  = ferr_cnt;
    hcnt = 0;
    cycles(2);
    bus.rx = 1'b0;
    cycles(1);
    bus.rx = 1'b1;
    for (int k = 0; k < 12 * C; k++) begin
      cycles(1);
      if (bus.busy === 1'b1) hcnt++;
    end
    checks++;
    if (hcnt < 1 || hcnt > C / 2 + 1) begin
      errors++; $display("FAIL glitch_busy got %0d cycles want 1..%0d", hcnt, C / 2 + 1);
    end
    checks++;
    if (got_q.size() != base || ferr_cnt != fe0) begin
      errors++; $display("FAIL glitch_pulses got valid %0d ferr %0d want 0 0", got_q.size() - base, ferr_cnt - fe0);
    end
  endtask

  task automatic test_frame_err;
    int base;
    int fe0;
    base = got_q.size();
    fe0  = ferr_cnt;
    send_frame(8'hA5, 1'b0);
    cycles(6);
    checks++;
    if (ferr_cnt != fe0 + 1) begin errors++; $display("FAIL ferr_count got %0d want 1", ferr_cnt - fe0); end
    checks++;
    if (got_q.size() != base) begin errors++; $display("FAIL ferr_valid got %0d want 0", got_q.size() - base); end
    checks++;
    if (bus.data !== last_good) begin errors++; $display("FAIL ferr_hold got %h want %h", bus.data, last_good); end
    send_frame(8'h3C, 1'b1);
    cycles(6);
    checks++;
    if (got_q.size() != base + 1 || got_q[got_q.size()-1] !== 8'h3C) begin
      errors++; $display("FAIL ferr_recover got %0d bytes last %h want 1 3c", got_q.size() - base, bus.data);
    end
    last_good = 8'h3C;
  endtask

  task automatic test_break;
    int base;
    int fe0;
    int bcnt;
    base = got_q.size();
    fe0  = ferr_cnt;
    bus.rx = 1'b0;
    cycles(40 * C);
    bus.rx = 1'b1;
    cycles(8);
    checks++;
    if (ferr_cnt != fe0 + 1) begin errors++; $display("FAIL break_ferr got %0d want 1", ferr_cnt - fe0); end
    checks++;
    if (got_q.size() != base) begin errors++; $display("FAIL break_valid got %0d want 0", got_q.size() - base); end

    bus.rx = 1'b0;
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    last_good = 8'h00;
    bcnt = 0;
    fe0 = ferr_cnt;
    for (int k = 0; k < 20 * C; k++) begin
      cycles(1);
      if (bus.busy !== 1'b0) bcnt++;
    end
    checks++;
    if (bcnt != 0 || ferr_cnt != fe0 || got_q.size() != base) begin
      errors++; $display("FAIL lowreset_idle got busy %0d ferr %0d valid %0d want 0 0 0", bcnt, ferr_cnt - fe0, got_q.size() - base);
    end
    bus.rx = 1'b1;
    cycles(3);
    send_frame(8'h5A, 1'b1);
    cycles(6);
    checks++;
    if (got_q.size() != base + 1 || got_q[got_q.size()-1] !== 8'h5A) begin
      errors++; $display("FAIL lowreset_frame got %0d bytes data %h want 1 5a", got_q.size() - base, bus.data);
    end
    last_good = 8'h5A;
  endtask

  task automatic test_mid_reset;
    logic [7:0] b;
    int base;
    int fe0;
    b    = 8'h2E;
    base = got_q.size();
    fe0  = ferr_cnt;
    bus.rx = 1'b0;
    cycles(C);
    for (int i = 0; i < 4; i++) begin
      bus.rx = b[i];
      cycles(C);
    end
    bus.rx = b[4];
    cycles(1);
    rst = 1'b1;
    cycles(1);
    checks++;
    if (bus.busy !== 1'b0 || bus.data !== 8'h00 || bus.valid !== 1'b0 || bus.frame_err !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got busy %b data %h valid %b ferr %b want 0 00 0 0", bus.busy, bus.data, bus.valid, bus.frame_err);
    end
    rst = 1'b0;
    bus.rx = 1'b1;
    last_good = 8'h00;
    cycles(12 * C);
    checks++;
    if (got_q.size() != base || ferr_cnt != fe0) begin
      errors++; $display("FAIL midrst_pulses got valid %0d ferr %0d want 0 0", got_q.size() - base, ferr_cnt - fe0);
    end
    send_frame(8'h81, 1'b1);
    cycles(6);
    checks++;
    if (got_q.size() != base + 1 || got_q[got_q.size()-1] !== 8'h81) begin
      errors++; $display("FAIL midrst_frame got %0d bytes data %h want 1 81", got_q.size() - base, bus.data);
    end
    last_good = 8'h81;
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic       good;
    int base;
    int fe0;
    int exp_fe;
    base = got_q.size();
    fe0  = ferr_cnt;
    exp_fe = 0;
    for (int n = 0; n < 12; n++) begin
      b    = 8'($urandom);
      good = ($urandom_range(3) != 0);
      send_frame(b, good);
      if (good) exp_q.push_back(b);
      else exp_fe++;
      cycles(good ? $urandom_range(3) : C + $urandom_range(3));
    end
    cycles(6);
    checks++;
    if (ferr_cnt - fe0 != exp_fe) begin errors++; $display("FAIL rand_ferr got %0d want %0d", ferr_cnt - fe0, exp_fe); end
    checks++;
    if (got_q.size() - base != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d want %0d", got_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL rand_data%0d got %h want %h", i, got_q[base+i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.rx = 1'b1;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_break();
    test_mid_reset();
    test_random();
    checks++;
    if (both_cnt != 0) begin errors++; $display("FAIL both_high got %0d want 0", both_cnt); end
    checks++;
    if (wide_cnt != 0) begin errors++; $display("FAIL pulse_width got %0d wide pulses want 0", wide_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
